prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PW, default 10, program-counter width in bits.
REQ-002 SHALL have parameter SD, default 4, return-stack depth in entries (2..16).
REQ-003 SHALL have parameter CW, default 16, cycle/instruction counter width in bits.
REQ-004 Clk  input  1  clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  load StartAddr and begin a program run.
REQ-007 StartAddr  input  PW  first instruction address of the run.
REQ-008 Stall  input  1  hold current instruction this cycle (no retire).
REQ-009 HaltOp  input  1  decoded current instruction is halt.
REQ-010 BranchAbs  input  1  absolute jump to Target.
REQ-011 BranchRelEn  input  1  relative branch, taken when Flag=1.
REQ-012 Flag  input  1  ALU condition flag for relative branch.
REQ-013 Call  input  1  push return address, jump to Target.
REQ-014 Ret  input  1  pop return address into ProgCtr.
REQ-015 Target  input  PW  absolute target, or two's-complement offset for relative branch.
REQ-016 ProgCtr  output  PW  current instruction address.
REQ-017 Ack  output  1  program done (HALT state).
REQ-018 Running  output  1  high in RUN state.
REQ-019 StackErr  output  1  sticky: return-stack overflow/underflow occurred.
REQ-020 CycleCt  output  CW  cycles spent in RUN.
REQ-021 InstCt  output  CW  instructions retired in RUN.

Function
REQ-022 States SHALL be IDLE, RUN, HALT; Ack=(state==HALT), Running=(state==RUN).
REQ-023 Start=1 in any state SHALL, next cycle: state RUN, ProgCtr=StartAddr, CycleCt=InstCt=0, stack empty, StackErr=0; held Start reloads each cycle, so execution begins the cycle after Start falls.
REQ-024 In IDLE/HALT without Start, ProgCtr, counters and stack SHALL hold; all control inputs ignored.
REQ-025 In RUN with Stall=1, ProgCtr, stack and InstCt SHALL hold; HaltOp and all branch/call/ret inputs ignored.
REQ-026 In RUN with Stall=0, next-PC priority SHALL be HaltOp > Ret > Call > BranchAbs > (BranchRelEn & Flag) > ProgCtr+1.
REQ-027 HaltOp SHALL hold ProgCtr and enter HALT next cycle; the halt instruction counts as retired.
REQ-028 Call SHALL push ProgCtr+1 (mod 2^PW) and load Target; Ret SHALL pop top entry into ProgCtr.
REQ-029 Relative branch SHALL load ProgCtr + Target (Target sign-extended, sum mod 2^PW); BranchRelEn with Flag=0 SHALL take ProgCtr+1.
REQ-030 Sequential increment SHALL wrap 2^PW-1 -> 0 with no error.
REQ-031 Call with stack full (SD entries) SHALL not push or jump, set StackErr, enter HALT next cycle.
REQ-032 Ret with stack empty SHALL not change ProgCtr, set StackErr, enter HALT next cycle.
REQ-033 CycleCt SHALL increment every cycle in RUN (stalled or not); InstCt SHALL increment on each non-stalled RUN cycle; both saturate at 2^CW-1.
REQ-034 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-035 Reset=1 SHALL, next cycle, give state IDLE, ProgCtr=0, Ack=0, Running=0, StackErr=0, CycleCt=InstCt=0, stack empty; Reset dominates Start.
REQ-036 Reset asserted mid-run SHALL abort the run with no residual stack contents.

Verification
REQ-037 Reset, Start=1 one cycle, StartAddr=0x010, 3 plain cycles, HaltOp -> ProgCtr 0x010,0x011,0x012,0x013 held; Ack=1; InstCt=4, CycleCt=4.
REQ-038 At ProgCtr=0x020: BranchRelEn=1,Flag=1,Target=0x3FE -> 0x01E; then BranchRelEn=1,Flag=0 -> 0x01F; then BranchAbs,Target=0x100 -> 0x100.
REQ-039 Call Target=0x080 at 0x005, Call Target=0x0C0 at 0x080, Ret, Ret -> 0x080,0x0C0,0x081,0x006; StackErr=0.
REQ-040 SD=4: five nested Calls -> fifth does not jump, StackErr=1, Ack=1 next cycle; Ret at reset-fresh run start -> StackErr=1, Ack=1.
REQ-041 Stall=1 for 3 cycles with Call and HaltOp asserted -> ProgCtr unchanged, CycleCt+3, InstCt+0; ProgCtr=0x3FF plain step -> 0x000.
REQ-042 Reset asserted at ProgCtr=0x045 with 2 stack entries -> IDLE, ProgCtr=0, counters 0; subsequent Ret after Start -> StackErr=1.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: IDLE/RUN/HALT control, next-PC selection with call/return stack,
// sticky stack error flag and saturating cycle/instruction counters.
module prog_sequencer #(
    parameter int unsigned PW = 10,
    parameter int unsigned SD = 4,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          HaltOp,
    input  logic          BranchAbs,
    input  logic          BranchRelEn,
    input  logic          Flag,
    input  logic          Call,
    input  logic          Ret,
    input  logic [PW-1:0] Target,
    output logic [PW-1:0] ProgCtr,
    output logic          Ack,
    output logic          Running,
    output logic          StackErr,
    output logic [CW-1:0] CycleCt,
    output logic [CW-1:0] InstCt
);

    localparam int unsigned SpW  = $clog2(SD + 1);
    localparam int unsigned IdxW = $clog2(SD);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [SpW-1:0]  sp_q, sp_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [CW-1:0]   inst_q, inst_d;
    logic [PW-1:0]   stack_q [SD];

    logic            push;
    logic [PW-1:0]   pc_inc;
    logic [IdxW-1:0] push_idx;
    logic [IdxW-1:0] top_idx;
    logic            stack_full;
    logic            stack_empty;

    assign pc_inc      = pc_q + PW'(1);
    assign push_idx    = IdxW'(sp_q);
    assign top_idx     = IdxW'(sp_q - SpW'(1));
    assign stack_full  = (sp_q == SpW'(SD));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        push    = 1'b0;

        if (Start) begin
            state_d = StRun;
            pc_d    = StartAddr;
            sp_d    = '0;
            err_d   = 1'b0;
            cyc_d   = '0;
            inst_d  = '0;
        end else if (state_q == StRun) begin
            if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
            if (!Stall) begin
                if (inst_q != '1) inst_d = inst_q + CW'(1);
                if (HaltOp) begin
                    state_d = StHalt;
                end else if (Ret) begin
                    if (stack_empty) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end else begin
                        pc_d = stack_q[top_idx];
                        sp_d = sp_q - SpW'(1);
                    end
                end else if (Call) begin
                    if (stack_full) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SpW'(1);
                        pc_d = Target;
                    end
                end else if (BranchAbs) begin
                    pc_d = Target;
                end else if (BranchRelEn && Flag) begin
                    // Two's-complement offset: modular add equals sign-extended add.
                    pc_d = pc_q + Target;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    // Entries above the stack pointer are dead, so the array needs no reset.
    always_ff @(posedge Clk) begin
        if (!Reset && push) stack_q[push_idx] <= pc_inc;
    end

    assign ProgCtr  = pc_q;
    assign Ack      = (state_q == StHalt);
    assign Running  = (state_q == StRun);
    assign StackErr = err_q;
    assign CycleCt  = cyc_q;
    assign InstCt   = inst_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus randomized stimulus, all checked
// against a queue-based behavioural model of the sequencer.
module tb_prog_sequencer;

    localparam int PW_T = 10;
    localparam int SD_T = 4;
    localparam int CW_T = 6;
    localparam int PCM  = 1 << PW_T;
    localparam int CMAX = (1 << CW_T) - 1;

    logic            Clk = 1'b0;
    logic            Reset, Start, Stall, HaltOp, BranchAbs, BranchRelEn, Flag, Call, Ret;
    logic [PW_T-1:0] StartAddr, Target;
    logic [PW_T-1:0] ProgCtr;
    logic            Ack, Running, StackErr;
    logic [CW_T-1:0] CycleCt, InstCt;

    int n_cmp = 0;
    int n_err = 0;

    // Model: 0 idle, 1 run, 2 halt
    int m_st, m_pc, m_cc, m_ic;
    bit m_err;
    int m_stk[$];

    prog_sequencer #(.PW(PW_T), .SD(SD_T), .CW(CW_T)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .HaltOp     (HaltOp),
        .BranchAbs  (BranchAbs),
        .BranchRelEn(BranchRelEn),
        .Flag       (Flag),
        .Call       (Call),
        .Ret        (Ret),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .Ack        (Ack),
        .Running    (Running),
        .StackErr   (StackErr),
        .CycleCt    (CycleCt),
        .InstCt     (InstCt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_step();
        int off;
        if (Reset) begin
            m_st = 0; m_pc = 0; m_err = 0; m_cc = 0; m_ic = 0;
            m_stk.delete();
        end else if (Start) begin
            m_st = 1; m_pc = int'(StartAddr); m_err = 0; m_cc = 0; m_ic = 0;
            m_stk.delete();
        end else if (m_st == 1) begin
            m_cc = sat(m_cc);
            if (!Stall) begin
                m_ic = sat(m_ic);
                if (HaltOp) begin
                    m_st = 2;
                end else if (Ret) begin
                    if (m_stk.size() == 0) begin
                        m_err = 1; m_st = 2;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end else if (Call) begin
                    if (m_stk.size() == SD_T) begin
                        m_err = 1; m_st = 2;
                    end else begin
                        m_stk.push_back((m_pc + 1) % PCM);
                        m_pc = int'(Target);
                    end
                end else if (BranchAbs) begin
                    m_pc = int'(Target);
                end else if (BranchRelEn && Flag) begin
                    off  = (int'(Target) >= PCM / 2) ? int'(Target) - PCM : int'(Target);
                    m_pc = (m_pc + off + PCM) % PCM;
                end else begin
                    m_pc = (m_pc + 1) % PCM;
                end
            end
        end
    endtask

    task automatic clr();
        Reset = 0; Start = 0; Stall = 0; HaltOp = 0; BranchAbs = 0; BranchRelEn = 0;
        Flag = 0; Call = 0; Ret = 0; StartAddr = '0; Target = '0;
    endtask

    // One clock: advance model with the applied inputs, then compare all outputs.
    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        chk("pc", 32'(ProgCtr), 32'(m_pc));
        chk("ack", 32'(Ack), 32'(m_st == 2));
        chk("running", 32'(Running), 32'(m_st == 1));
        chk("stackerr", 32'(StackErr), 32'(m_err));
        chk("cyclect", 32'(CycleCt), 32'(m_cc));
        chk("instct", 32'(InstCt), 32'(m_ic));
    endtask

    task automatic do_start(input int addr);
        clr(); Start = 1; StartAddr = PW_T'(addr); cycle(); clr();
    endtask

    task automatic do_reset();
        clr(); Reset = 1; cycle(); clr();
    endtask

    initial begin
        int r;
        clr();
        m_st = 0; m_pc = 0; m_err = 0; m_cc = 0; m_ic = 0;

        // Reset state, and reset dominating Start
        do_reset();
        chk("rst_pc", 32'(ProgCtr), 32'h0);
        chk("rst_run", 32'(Running), 32'h0);
        Reset = 1; Start = 1; StartAddr = 10'h155; cycle(); clr();
        chk("rst_dom_run", 32'(Running), 32'h0);
        chk("rst_dom_pc", 32'(ProgCtr), 32'h0);

        // Straight-line run then halt
        do_start(10'h010);
        chk("seq_first", 32'(ProgCtr), 32'h010);
        repeat (3) cycle();
        HaltOp = 1; cycle(); clr();
        repeat (2) cycle();
        chk("seq_pc", 32'(ProgCtr), 32'h013);
        chk("seq_ack", 32'(Ack), 32'h1);
        chk("seq_inst", 32'(InstCt), 32'd4);
        chk("seq_cyc", 32'(CycleCt), 32'd4);

        // Branches
        do_start(10'h020);
        BranchRelEn = 1; Flag = 1; Target = 10'h3FE; cycle();
        chk("brel_taken", 32'(ProgCtr), 32'h01E);
        Flag = 0; cycle();
        chk("brel_not", 32'(ProgCtr), 32'h01F);
        clr(); BranchAbs = 1; Target = 10'h100; cycle(); clr();
        chk("babs", 32'(ProgCtr), 32'h100);

        // Nested call/return
        do_start(10'h005);
        Call = 1; Target = 10'h080; cycle();
        chk("call1", 32'(ProgCtr), 32'h080);
        Target = 10'h0C0; cycle(); clr();
        chk("call2", 32'(ProgCtr), 32'h0C0);
        Ret = 1; cycle();
        chk("ret1", 32'(ProgCtr), 32'h081);
        cycle(); clr();
        chk("ret2", 32'(ProgCtr), 32'h006);
        chk("ret_err", 32'(StackErr), 32'h0);

        // Stack overflow on fifth call
        do_start(10'h000);
        for (int i = 0; i < 4; i++) begin
            Call = 1; Target = PW_T'(10'h040 + i * 16); cycle();
        end
        Target = 10'h200; cycle(); clr();
        chk("ovf_pc", 32'(ProgCtr), 32'h070);
        chk("ovf_err", 32'(StackErr), 32'h1);
        chk("ovf_ack", 32'(Ack), 32'h1);

        // Underflow on fresh run
        do_start(10'h033);
        chk("start_clr_err", 32'(StackErr), 32'h0);
        Ret = 1; cycle(); clr();
        chk("unf_err", 32'(StackErr), 32'h1);
        chk("unf_ack", 32'(Ack), 32'h1);
        chk("unf_pc", 32'(ProgCtr), 32'h033);

        // Stall holds PC and InstCt while CycleCt advances
        do_start(10'h123);
        Stall = 1; Call = 1; HaltOp = 1; Target = 10'h2AA;
        repeat (3) cycle();
        clr();
        chk("stall_pc", 32'(ProgCtr), 32'h123);
        chk("stall_cyc", 32'(CycleCt), 32'd3);
        chk("stall_inst", 32'(InstCt), 32'd0);

        // PC wrap
        do_start(10'h3FF);
        cycle();
        chk("wrap", 32'(ProgCtr), 32'h000);

        // Counter saturation
        repeat (70) cycle();
        chk("sat_cyc", 32'(CycleCt), 32'(CMAX));
        chk("sat_inst", 32'(InstCt), 32'(CMAX));

        // Reset mid-run with two stack entries
        do_start(10'h010);
        Call = 1; Target = 10'h020; cycle();
        Target = 10'h045; cycle(); clr();
        chk("pre_rst_pc", 32'(ProgCtr), 32'h045);
        do_reset();
        chk("mid_rst_pc", 32'(ProgCtr), 32'h0);
        chk("mid_rst_cyc", 32'(CycleCt), 32'h0);
        chk("mid_rst_idle", 32'(Running), 32'h0);
        do_start(10'h050);
        Ret = 1; cycle(); clr();
        chk("mid_rst_unf", 32'(StackErr), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clr();
            r           = $urandom_range(0, 199);
            Reset       = (r < 2);
            Start       = (r >= 2 && r < 8);
            StartAddr   = ($urandom_range(0, 3) == 0) ? PW_T'(10'h3FC + $urandom_range(0, 3))
                                                      : PW_T'($urandom);
            Stall       = ($urandom_range(0, 9) < 2);
            HaltOp      = ($urandom_range(0, 79) == 0);
            Ret         = ($urandom_range(0, 99) < 12);
            Call        = ($urandom_range(0, 99) < 15);
            BranchAbs   = ($urandom_range(0, 99) < 10);
            BranchRelEn = ($urandom_range(0, 99) < 25);
            Flag        = 1'($urandom);
            Target      = PW_T'($urandom);
            cycle();
        end
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
